// File: rtl/reflet_bus_responder_pkg.sv
// Shared definitions for the bus responder: MMIO register slots (in units of
// one bus word) and STATUS bit positions.
package reflet_bus_responder_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_TXDATA  = 2'd1,
    REG_CYCLES  = 2'd2,
    REG_SCRATCH = 2'd3
  } mmio_reg_e;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 4;
  localparam int STATUS_COUNT_WIDTH  = 4;

endpackage

// File: rtl/reflet_byte_fifo.sv
// Byte FIFO feeding the output stream; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module reflet_byte_fifo #(
  parameter int depth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(depth):0]  count,
  output logic [7:0]              head
);

  localparam int PW = $clog2(depth);

  logic [7:0]    storage [depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(depth));
  assign empty   = (count == '0);
  assign head    = storage[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and count define
  // which entries are meaningful, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/reflet_bus_responder.sv
// Target side of the CPU memory bus: word RAM from address 0 plus an MMIO
// window with STATUS, TXDATA (byte FIFO), CYCLES and SCRATCH.
module reflet_bus_responder
  import reflet_bus_responder_pkg::*;
#(
  parameter int                  wordsize      = 16,
  parameter int                  ram_addr_bits = 10,
  parameter logic [wordsize-1:0] io_base       = 16'hFF00,
  parameter int                  fifo_depth    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] wr_data,
  input  logic                write_en,
  output logic [wordsize-1:0] rd_data,
  output logic [7:0]          fifo_data,
  output logic                fifo_valid,
  input  logic                fifo_ready
);

  localparam int B         = wordsize / 8;
  localparam int LG        = $clog2(B);
  localparam int RAM_WORDS = (2 ** ram_addr_bits) / B;
  localparam int CW        = $clog2(fifo_depth) + 1;

  // One extra bit keeps the window's upper bound from wrapping at the top
  // of the address space.
  localparam logic [wordsize:0] RAM_LIMIT = (wordsize+1)'(1) << ram_addr_bits;
  localparam logic [wordsize:0] IO_LO     = {1'b0, io_base};
  localparam logic [wordsize:0] IO_HI     = IO_LO + (wordsize+1)'(4 * B);

  logic [wordsize-1:0] ram [RAM_WORDS];
  logic [wordsize-1:0] cycles;
  logic [wordsize-1:0] scratch;
  logic                overflow;

  logic [wordsize:0]   addr_x;
  logic                ram_sel;
  logic                io_sel;
  mmio_reg_e           io_reg;
  logic                bus_wr;
  logic                push_req;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [3:0]          count_sat;
  logic [wordsize-1:0] status_word;
  logic [wordsize-1:0] rd_next;

  assign addr_x   = {1'b0, addr};
  assign ram_sel  = (addr_x < RAM_LIMIT);
  assign io_sel   = (addr_x >= IO_LO) && (addr_x < IO_HI);
  assign io_reg   = mmio_reg_e'(addr[LG+1:LG]);
  assign bus_wr   = enable && write_en;
  assign push_req = bus_wr && io_sel && (io_reg == REG_TXDATA);
  assign pop      = fifo_valid && fifo_ready;

  assign fifo_valid = (fifo_count != '0);

  reflet_byte_fifo #(.depth(fifo_depth)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (wr_data[7:0]),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_data)
  );

  assign count_sat = (32'(fifo_count) > 15) ? 4'hF : 4'(fifo_count);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    status_word = '0;
    status_word[STATUS_FULL_BIT]     = fifo_full;
    status_word[STATUS_EMPTY_BIT]    = fifo_empty;
    status_word[STATUS_OVERFLOW_BIT] = overflow;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_WIDTH] = count_sat;
  end

  always_comb begin
    rd_next = '0;
    if (ram_sel) begin
      rd_next = ram[addr[ram_addr_bits-1:LG]];
    end else if (io_sel) begin
      case (io_reg)
        REG_STATUS:  rd_next = status_word;
        REG_CYCLES:  rd_next = cycles;
        REG_SCRATCH: rd_next = scratch;
        default:     rd_next = '0;
      endcase
    end
  end

  // Reads sample pre-edge state, so a same-cycle write returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (enable) begin
      rd_data <= rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && bus_wr && ram_sel) ram[addr[ram_addr_bits-1:LG]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles   <= '0;
      scratch  <= '0;
      overflow <= 1'b0;
    end else begin
      if (enable) begin
        if (bus_wr && io_sel && io_reg == REG_CYCLES) cycles <= wr_data;
        else                                          cycles <= cycles + 1'b1;
      end
      if (bus_wr && io_sel && io_reg == REG_SCRATCH) scratch <= wr_data;
      if (bus_wr && io_sel && io_reg == REG_STATUS) begin
        overflow <= 1'b0;
      end else if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reflet_bus_responder.sv
// Directed bench for reflet_bus_responder: RAM, read-before-write, FIFO,
// CYCLES wrap and hold, SCRATCH, unmapped space and mid-stream reset.
module tb_reflet_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        write_en;
  logic [15:0] rd_data;
  logic [7:0]  fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reflet_bus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .addr       (addr),
    .wr_data    (wr_data),
    .write_en   (write_en),
    .rd_data    (rd_data),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_ready (fifo_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr = a; wr_data = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input string tag, input logic [15:0] exp);
    addr = a; write_en = 1'b0;
    tick();
    check(tag, rd_data, exp);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; addr = '0; wr_data = '0;
    write_en = 1'b0; fifo_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_rd_data", rd_data, 16'h0000);
    check("reset_fifo_valid", fifo_valid, 1'b0);
    bus_read(16'hFF00, "reset_status", 16'h0002);
    bus_read(16'hFF06, "reset_scratch", 16'h0000);

    // RAM: neighbouring words stay separate, low address bit is ignored
    bus_write(16'h0012, 16'h0111);
    bus_write(16'h0010, 16'hBEEF);
    bus_read(16'h0010, "ram_beef", 16'hBEEF);
    bus_read(16'h0012, "ram_neighbour", 16'h0111);
    bus_read(16'h0011, "ram_low_bit_ignored", 16'hBEEF);
    bus_write(16'h03FE, 16'h7777);
    bus_read(16'h03FE, "ram_last_word", 16'h7777);
    bus_read(16'h0400, "past_ram_unmapped", 16'h0000);

    // Read-before-write on the same word
    bus_write(16'h0020, 16'h1234);
    bus_write(16'h0020, 16'h5678);
    check("rbw_old_value", rd_data, 16'h1234);
    bus_read(16'h0020, "rbw_new_value", 16'h5678);

    // Fill the FIFO, then overflow it
    for (int i = 0; i < 4; i++) bus_write(16'hFF02, 16'h00A1 + 16'(i));
    bus_read(16'hFF00, "status_full", 16'h0041);
    bus_write(16'hFF02, 16'h00A5);
    bus_read(16'hFF00, "status_overflow", 16'h0045);
    bus_read(16'hFF02, "txdata_reads_zero", 16'h0000);
    fifo_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop_valid_%0d", i), fifo_valid, 1'b1);
      check($sformatf("pop_data_%0d", i), fifo_data, 8'hA1 + 8'(i));
      tick();
    end
    check("drained_valid", fifo_valid, 1'b0);
    fifo_ready = 1'b0;
    bus_write(16'hFF00, 16'h0000);
    bus_read(16'hFF00, "overflow_cleared", 16'h0002);

    // Push into a full FIFO while popping: accepted, no overflow
    for (int i = 0; i < 4; i++) bus_write(16'hFF02, 16'h00A1 + 16'(i));
    fifo_ready = 1'b1;
    bus_write(16'hFF02, 16'h00B0);
    fifo_ready = 1'b0;
    bus_read(16'hFF00, "full_push_pop_status", 16'h0041);
    fifo_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop2_data_%0d", i), fifo_data, (i == 3) ? 8'hB0 : 8'hA2 + 8'(i));
      tick();
    end
    check("drained2_valid", fifo_valid, 1'b0);
    fifo_ready = 1'b0;

    // CYCLES: load, wrap, freeze while disabled
    bus_write(16'hFF04, 16'hFFFE);
    bus_read(16'hFF04, "cycles_load", 16'hFFFE);
    bus_read(16'hFF04, "cycles_ffff", 16'hFFFF);
    bus_read(16'hFF04, "cycles_wrap", 16'h0000);
    bus_read(16'hFF04, "cycles_one", 16'h0001);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) bus_read(16'hFF04, $sformatf("hold_rd_%0d", i), 16'h0001);
    enable = 1'b1;
    bus_read(16'hFF04, "cycles_resume", 16'h0002);

    // SCRATCH: disabled writes ignored, enabled write lands
    enable = 1'b0;
    bus_write(16'hFF06, 16'h5555);
    enable = 1'b1;
    bus_read(16'hFF06, "scratch_disabled_write", 16'h0000);
    bus_write(16'hFF06, 16'hA5A5);
    bus_read(16'hFF06, "scratch_rw", 16'hA5A5);

    // Unmapped
    bus_write(16'h8000, 16'h9999);
    bus_read(16'h8000, "unmapped_read", 16'h0000);

    // Reset mid-stream discards queued bytes and the pending write
    bus_write(16'hFF02, 16'h00C1);
    bus_write(16'hFF02, 16'h00C2);
    check("queued_valid", fifo_valid, 1'b1);
    addr = 16'hFF06; wr_data = 16'h1111; write_en = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; write_en = 1'b0;
    check("midreset_fifo_valid", fifo_valid, 1'b0);
    check("midreset_rd_data", rd_data, 16'h0000);
    bus_read(16'hFF06, "midreset_scratch", 16'h0000);
    bus_read(16'hFF00, "midreset_status", 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reflet_bus_responder.md
Name: reflet_bus_responder

Overview:
- Target-side end of the CPU memory bus: answers the core's address/read/write traffic with a word-organised RAM plus a small MMIO window.
- MMIO window holds a byte output FIFO, a free-running cycle counter and a scratch register.
- Sits between the core's address unit and the top-level peripherals.
- The core's writer always sends full merged words, so this block handles only whole-word reads and writes.

Parameters:
wordsize, 16, bus width in bits; multiple of 8, at least 16
ram_addr_bits, 10, RAM size is 2^ram_addr_bits bytes, decoded from byte address 0
io_base, 16'hFF00, byte base of the MMIO window; aligned to 4*(wordsize/8)
fifo_depth, 4, output FIFO entries; power of 2, at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  bus-side clock enable; when low, all bus-side state holds
addr  in  wordsize  byte address from the core
wr_data  in  wordsize  word written by the core
write_en  in  1  write strobe, one cycle per access
rd_data  out  wordsize  registered read data
fifo_data  out  8  head byte of the output FIFO
fifo_valid  out  1  FIFO not empty
fifo_ready  in  1  consumer accepts the head byte

Behaviour:
- Word index: B = wordsize/8, w = addr >> log2(B); the low log2(B) address bits are ignored.
- Decode:
  - RAM when addr < 2^ram_addr_bits.
  - MMIO when io_base <= addr < io_base+4B:
    - io_base+0 STATUS
    - io_base+B TXDATA
    - io_base+2B CYCLES
    - io_base+3B SCRATCH
  - Everything else is unmapped.
- Read path:
  - Every enabled cycle, rd_data <= value selected by the current addr, so read latency is exactly 1 cycle.
  - No request strobe; reads have no side effects.
- Write path: in an enabled cycle with write_en=1, the decoded target is updated at that edge.
- Same-cycle read and write to the same location: rd_data returns the OLD value (read-before-write). The next cycle returns the new value.
- RAM: 2^ram_addr_bits/B words; full-word write; contents not reset and undefined until written.
- STATUS read, zero-extended:
  - bit0 full
  - bit1 empty
  - bit2 overflow (sticky)
  - bits[7:4] occupancy count, saturating at 15
- STATUS write: any write clears overflow; data is ignored.
- TXDATA write: pushes wr_data[7:0]. TXDATA reads return 0.
- Push acceptance:
  - Accepted if not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- Pop:
  - Occurs when fifo_valid & fifo_ready, independent of enable.
  - fifo_data shows the head combinationally from the storage array.
  - fifo_valid equals count != 0.
- Simultaneous push and pop: count is unchanged, pointers both advance.
- Empty with a simultaneous push: no pop (fifo_valid=0); the new byte is visible the next cycle.
- CYCLES:
  - Increments by 1 each enabled cycle and wraps modulo 2^wordsize.
  - A write loads wr_data, and the increment resumes the following cycle.
- SCRATCH: plain read/write register.
- Unmapped accesses: reads return 0, writes are ignored.
- Reset, synchronous and dominant over enable:
  - rd_data=0, CYCLES=0, SCRATCH=0, overflow=0.
  - FIFO pointers and count are 0, so fifo_valid=0 and fifo_data is don't-care.
- Reset mid-operation discards queued bytes and any pending write in that cycle.
- enable low:
  - rd_data, RAM, CYCLES and SCRATCH hold.
  - Writes and pushes are ignored.
  - FIFO pops still occur.

Decomposition:
- Shared header, included like the core's: MMIO offsets (STATUS, TXDATA, CYCLES, SCRATCH, as multiples of B) and STATUS bit positions.
- One sub-module, reflet_byte_fifo (params depth; push, push_data, pop, full, empty, count, head), instantiated once.
- Decode, RAM array, counter and read mux stay in the top.

Test Plan:
- Reset, then write 16'hBEEF to addr 16'h0010, then read 16'h0010 -> rd_data=16'hBEEF one cycle after addr is presented; 16'h0012 still reads its prior or undefined value, never BEEF.
- Write 16'h1234 then 16'h5678 to 16'h0020 with a read of the same address in the second write's cycle -> that cycle's rd_data=16'h1234, next cycle 16'h5678.
- Push 4 bytes 8'hA1..8'hA4 to 16'hFF02 with fifo_ready=0, then push 8'hA5 -> STATUS reads 16'h0041 after 4 pushes; after the fifth push STATUS=16'h0045 and A5 is dropped. Raise fifo_ready -> pops A1,A2,A3,A4 on consecutive cycles, then fifo_valid=0.
- FIFO full with fifo_ready=1 and a push of 8'hB0 in the same cycle -> push accepted, overflow stays 0, count stays 4, B0 emerges after A4.
- Write 16'hFFFE to CYCLES at 16'hFF04, hold enable=1, read it back -> value wraps through 0; drop enable for 3 cycles -> rd_data and CYCLES freeze.
- Read 16'h8000 (unmapped) -> 0; mid-stream assert reset with 2 queued bytes -> next cycle fifo_valid=0, SCRATCH=0, rd_data=0.
